fetch_issue_unit: RTL
=====================

Name: fetch_issue_unit

Overview:
Front end of the pipeline and the producer side of the CU's Opcode/INT interface. It fetches 16-bit instruction words from instruction memory, assembles two-word (immediate) instructions, and injects the interrupt pseudo-instruction (Opcode=0, INT=1). It presents one registered decode packet per issued instruction to the CU/decode stage, with stall and redirect/flush handling.

Parameters:
ADDR_W, 20, PC and instruction-memory address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
imem_addr  out  ADDR_W  instruction memory address; combinational copy of PC
imem_data  in  16  instruction word at imem_addr, same cycle (combinational read)
stall  in  1  hazard stall from decode; hold PC, state and all outputs
pc_load  in  1  redirect from jump/call/ret/rti/int-vector logic
pc_target  in  ADDR_W  redirect address
int_req  in  1  external interrupt request
Opcode  out  8  opcode to CU; NOP 8'b11_100_010 when valid=0
INT  out  1  interrupt pseudo-instruction flag to CU
Rsrc  out  3  source register field
Rdst  out  3  destination register field
Imm  out  16  immediate word; 0 for single-word instructions
ret_pc  out  ADDR_W  address of the next sequential instruction (return address for CALL/INT)
valid  out  1  packet on outputs is a real instruction

Behaviour:
- Word format: [15:8] opcode, [7:5] Rsrc, [4:2] Rdst, [1:0] unused.
- Two-word instructions: opcode[7:6]==2'b01 (LDM, SHL, SHR), LDD 00_001_000, STD 00_010_000. The following word is Imm.
- Reset (async): PC=RESET_PC, state=FETCH, Opcode=NOP, INT=0, Rsrc=Rdst=0, Imm=0, ret_pc=0, valid=0, int_pending=0.
- All outputs are registered. imem_addr=PC is combinational.
- States:
  - FETCH, single-word: next edge registers the packet, sets valid=1, ret_pc=PC+1, PC<=PC+1. Latency is 1 cycle; throughput is 1 instruction/cycle.
  - FETCH, two-word: latch opcode/fields into the hold register, PC<=PC+1, next valid=0 (NOP), go to FETCH_IMM.
  - FETCH_IMM: register the held fields plus Imm=imem_data, valid=1, ret_pc=PC+1, PC<=PC+1, go to FETCH.
  - INT_ISSUE: entered from FETCH at an instruction boundary when int_pending=1. Emit Opcode=8'h00, INT=1, valid=1, ret_pc=PC (the unfetched instruction), PC unchanged. Clear int_pending, go to INT_WAIT.
  - INT_WAIT: valid=0, no fetch, PC held until pc_load.
- int_req: sampled every cycle and sets int_pending (sticky). Repeated requests while pending merge into one. Requests during INT_WAIT stay pending and are taken after the redirect, at the next FETCH boundary.
- Priority, highest first: rst > pc_load > stall > interrupt issue > normal fetch.
  - pc_load: PC<=pc_target, state<=FETCH, hold register discarded (a two-word instruction caught mid-assembly is dropped), next valid=0. Applies even while stall=1.
  - stall (no pc_load): PC, state, hold register and all outputs unchanged. An interrupt is never taken during stall.
- INT is 1 only on the single valid INT_ISSUE packet. On every other cycle INT=0.
- PC arithmetic is modulo 2^ADDR_W. Fetch past the top address wraps to 0. A two-word instruction at the top address takes its Imm from address 0.
- Reset mid-assembly or in INT_WAIT returns to the reset values immediately (async).

Decomposition:
- Shared package (cpu_pkg):
  - opcode localparams (NOP, LDM, LDD, STD, SHL, SHR);
  - function is_two_word(opcode);
  - fetch state enum FETCH/FETCH_IMM/INT_ISSUE/INT_WAIT;
  - field-position constants for the word format.
- No sub-module is needed. The single-module FSM plus PC and hold registers fits in roughly 200 lines.

Test Plan:
- Reset release, memory {0:16'h0004 (ADD R0,R1), 1:16'h0108 (SUB)} → cycle 1: Opcode=00_000_000, Rdst=1, valid=1, ret_pc=1; cycle 2: Opcode=00_000_001, ret_pc=2.
- mem[0]=16'h6004 (LDM Rdst=1), mem[1]=16'hBEEF → cycle 1: valid=0, Opcode=NOP; cycle 2: Opcode=01_100_000, Imm=16'hBEEF, Rdst=1, valid=1, PC=2.
- int_req pulse for 1 cycle during a stream at PC=5 → after the current packet: Opcode=8'h00, INT=1, valid=1, ret_pc=5; then valid=0 until pc_load with pc_target=20'h00100 → the next packet is fetched from 0x00100 with INT=0.
- stall=1 for 3 cycles with an ADD on the outputs → outputs and imem_addr frozen for 3 cycles; resume with no lost or duplicated instruction.
- pc_load=1 during FETCH_IMM of an LDD at PC=9, target 0x40 → LDD never appears with valid=1; the next valid packet comes from address 0x40.
- int_req asserted while stall=1 and on the FETCH_IMM cycle → INT packet issued only after stall clears and after the two-word packet completes; exactly one INT packet.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, word-format field positions and fetch FSM types
// for the front end of the pipeline.
package cpu_pkg;

   localparam logic [7:0] OP_NOP = 8'b11_100_010;
   localparam logic [7:0] OP_LDM = 8'b01_100_000;
   localparam logic [7:0] OP_SHL = 8'b01_000_000;
   localparam logic [7:0] OP_SHR = 8'b01_001_000;
   localparam logic [7:0] OP_LDD = 8'b00_001_000;
   localparam logic [7:0] OP_STD = 8'b00_010_000;

   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 8;
   localparam int RSRC_HI = 7;
   localparam int RSRC_LO = 5;
   localparam int RDST_HI = 4;
   localparam int RDST_LO = 2;

   typedef enum logic [1:0] {FETCH, FETCH_IMM, INT_ISSUE, INT_WAIT} fetch_state_t;

   typedef struct packed {
      logic [7:0] opcode;
      logic [2:0] rsrc;
      logic [2:0] rdst;
   } fields_t;

   // The whole 01 class (LDM/SHL/SHR) carries an immediate, plus LDD and STD.
   function automatic logic is_two_word(input logic [7:0] op);
      return (op[7:6] == OP_LDM[7:6]) || (op[7:6] == OP_SHL[7:6]) ||
             (op[7:6] == OP_SHR[7:6]) || (op == OP_LDD) || (op == OP_STD);
   endfunction

   function automatic fields_t decode_fields(input logic [15:0] w);
      fields_t f;
      f.opcode = w[OPC_HI:OPC_LO];
      f.rsrc   = w[RSRC_HI:RSRC_LO];
      f.rdst   = w[RDST_HI:RDST_LO];
      return f;
   endfunction

endpackage

// File: rtl/fetch_issue_unit.sv
// Instruction fetch and issue: assembles two-word instructions, injects the
// interrupt pseudo-instruction and presents one registered packet per issue.
module fetch_issue_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_data,
   input  logic              stall,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   input  logic              int_req,
   output logic [7:0]        Opcode,
   output logic              INT,
   output logic [2:0]        Rsrc,
   output logic [2:0]        Rdst,
   output logic [15:0]       Imm,
   output logic [ADDR_W-1:0] ret_pc,
   output logic              valid
);

   fetch_state_t      state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, pc_inc;
   fields_t           hold, hold_n, word, iss_f;
   logic              int_pending, pend_n;
   logic [7:0]        opcode_n;
   logic              int_n, valid_n;
   logic [2:0]        rsrc_n, rdst_n;
   logic [15:0]       imm_n, iss_imm;
   logic [ADDR_W-1:0] ret_n;
   logic              do_issue, do_bubble;
   logic              unused_bits;

   assign imem_addr   = pc;
   assign pc_inc      = pc + 1'b1;
   assign word        = decode_fields(imem_data);
   assign unused_bits = ^imem_data[1:0];

   always_comb begin
      state_n   = state;
      pc_n      = pc;
      hold_n    = hold;
      pend_n    = int_pending | int_req;
      opcode_n  = Opcode;
      int_n     = INT;
      rsrc_n    = Rsrc;
      rdst_n    = Rdst;
      imm_n     = Imm;
      ret_n     = ret_pc;
      valid_n   = valid;
      do_issue  = 1'b0;
      do_bubble = 1'b0;
      iss_f     = word;
      iss_imm   = '0;

      if (pc_load) begin
         // Redirect wins over stall and drops any half-assembled instruction.
         pc_n      = pc_target;
         state_n   = FETCH;
         do_bubble = 1'b1;
      end else if (!stall) begin
         case (state)
            FETCH: begin
               if (int_pending) begin
                  opcode_n = 8'h00;
                  int_n    = 1'b1;
                  rsrc_n   = '0;
                  rdst_n   = '0;
                  imm_n    = '0;
                  ret_n    = pc;
                  valid_n  = 1'b1;
                  pend_n   = 1'b0;
                  state_n  = INT_ISSUE;
               end else if (is_two_word(word.opcode)) begin
                  hold_n    = word;
                  pc_n      = pc_inc;
                  state_n   = FETCH_IMM;
                  do_bubble = 1'b1;
               end else begin
                  do_issue = 1'b1;
               end
            end
            FETCH_IMM: begin
               iss_f    = hold;
               iss_imm  = imem_data;
               do_issue = 1'b1;
               state_n  = FETCH;
            end
            INT_ISSUE: begin
               do_bubble = 1'b1;
               state_n   = INT_WAIT;
            end
            default: do_bubble = 1'b1;
         endcase
      end

      if (do_issue) begin
         opcode_n = iss_f.opcode;
         int_n    = 1'b0;
         rsrc_n   = iss_f.rsrc;
         rdst_n   = iss_f.rdst;
         imm_n    = iss_imm;
         ret_n    = pc_inc;
         valid_n  = 1'b1;
         pc_n     = pc_inc;
      end
      // ret_pc is left as-is on bubbles; only valid packets define it.
      if (do_bubble) begin
         opcode_n = OP_NOP;
         int_n    = 1'b0;
         rsrc_n   = '0;
         rdst_n   = '0;
         imm_n    = '0;
         valid_n  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         hold        <= '0;
         int_pending <= 1'b0;
         Opcode      <= OP_NOP;
         INT         <= 1'b0;
         Rsrc        <= '0;
         Rdst        <= '0;
         Imm         <= '0;
         ret_pc      <= '0;
         valid       <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         hold        <= hold_n;
         int_pending <= pend_n;
         Opcode      <= opcode_n;
         INT         <= int_n;
         Rsrc        <= rsrc_n;
         Rdst        <= rdst_n;
         Imm         <= imm_n;
         ret_pc      <= ret_n;
         valid       <= valid_n;
      end
   end

endmodule
